// File: rtl/multi_clk_generator.sv
// Multi-channel event clock generator: each channel fires on a wrap-safe
// comparison of a shared timestamp against a drift-free due register.
module multi_clk_generator #(
  parameter int unsigned NCH = 4,
  parameter int unsigned W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     count,
  input  logic [NCH-1:0]   en,
  input  logic [NCH-1:0]   mode,
  input  logic [NCH*W-1:0] limit,
  input  logic [NCH-1:0]   ovr_clr,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   overrun
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [W-1:0] lim;
    logic [W-1:0] nd;
    logic [W-1:0] diff_now;
    logic [W-1:0] diff_nd;
    logic         reached;
    logic         nd_reached;
    logic         idle;

    logic [W-1:0] due_q;
    logic [W-1:0] due_d;
    logic         clk_out_q;
    logic         clk_out_d;
    logic         tick_q;
    logic         tick_d;
    logic         overrun_q;
    logic         overrun_d;

    assign lim        = limit[i*W +: W];
    assign nd         = due_q + lim;
    assign diff_now   = count - due_q;
    assign diff_nd    = count - nd;
    // Sign bit of the modular difference gives a wrap-safe count >= due.
    assign reached    = ~diff_now[W-1];
    assign nd_reached = ~diff_nd[W-1];
    assign idle       = ~en[i] || (lim == '0);

    always_comb begin
      due_d     = due_q;
      clk_out_d = clk_out_q;
      tick_d    = 1'b0;
      overrun_d = overrun_q & ~ovr_clr[i];

      if (idle) begin
        due_d     = count + lim;
        clk_out_d = 1'b0;
      end else if (reached) begin
        tick_d    = 1'b1;
        clk_out_d = mode[i] ? 1'b1 : ~clk_out_q;
        // Fell behind by a full interval: resync to now and drop missed events.
        if (nd_reached) begin
          due_d     = count + lim;
          overrun_d = 1'b1;
        end else begin
          due_d = nd;
        end
      end else if (mode[i]) begin
        clk_out_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        due_q     <= count + lim;
        clk_out_q <= 1'b0;
        tick_q    <= 1'b0;
        overrun_q <= 1'b0;
      end else begin
        due_q     <= due_d;
        clk_out_q <= clk_out_d;
        tick_q    <= tick_d;
        overrun_q <= overrun_d;
      end
    end

    assign clk_out[i] = clk_out_q;
    assign tick[i]    = tick_q;
    assign overrun[i] = overrun_q;
  end

endmodule

// File: tb/tb_multi_clk_generator.sv
// Directed self-checking bench for multi_clk_generator (W=8, two channels).
module tb_multi_clk_generator;

  localparam int unsigned W   = 8;
  localparam int unsigned NCH = 2;

  logic             clk;
  logic             rst;
  logic [W-1:0]     count;
  logic [NCH-1:0]   en;
  logic [NCH-1:0]   mode;
  logic [W-1:0]     lim0;
  logic [W-1:0]     lim1;
  logic [NCH-1:0]   ovr_clr;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   overrun;

  int errors = 0;
  int checks = 0;

  multi_clk_generator #(.NCH(NCH), .W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .count   (count),
    .en      (en),
    .mode    (mode),
    .limit   ({lim1, lim0}),
    .ovr_clr (ovr_clr),
    .clk_out (clk_out),
    .tick    (tick),
    .overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle outputs before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 2'b00; mode = 2'b00; lim0 = 8'd4; lim1 = 8'd0;
    count = 8'd0; ovr_clr = 2'b00;
    step();
    checks++;
    if (clk_out !== 2'b00) begin errors++; $display("FAIL reset clk_out got=%b exp=00", clk_out); end
    checks++;
    if (tick !== 2'b00) begin errors++; $display("FAIL reset tick got=%b exp=00", tick); end
    checks++;
    if (overrun !== 2'b00) begin errors++; $display("FAIL reset overrun got=%b exp=00", overrun); end
  endtask

  task automatic test_toggle();
    logic exp_clk;
    logic exp_tick;
    exp_clk = 1'b0;
    rst = 1'b0; en = 2'b01;
    for (int c = 1; c <= 24; c++) begin
      count = 8'(c);
      step();
      exp_tick = (c % 4 == 0);
      if (exp_tick) exp_clk = ~exp_clk;
      checks++;
      if (tick !== {1'b0, exp_tick}) begin
        errors++; $display("FAIL toggle tick c=%0d got=%b exp=%b", c, tick, {1'b0, exp_tick});
      end
      checks++;
      if (clk_out !== {1'b0, exp_clk}) begin
        errors++; $display("FAIL toggle clk_out c=%0d got=%b exp=%b", c, clk_out, {1'b0, exp_clk});
      end
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] c;
    logic exp_tick;
    rst = 1'b1; count = 8'hFA; lim0 = 8'd4; lim1 = 8'd0; en = 2'b01; mode = 2'b00;
    step();
    rst = 1'b0;
    c = 8'hFB;
    for (int n = 0; n < 12; n++) begin
      count = c;
      step();
      exp_tick = (c == 8'hFE) || (c == 8'h02) || (c == 8'h06);
      checks++;
      if (tick[0] !== exp_tick) begin
        errors++; $display("FAIL wrap tick count=%h got=%b exp=%b", c, tick[0], exp_tick);
      end
      c = c + 8'd1;
    end
    checks++;
    if (overrun !== 2'b00) begin errors++; $display("FAIL wrap overrun got=%b exp=00", overrun); end
  endtask

  task automatic test_pulse();
    logic [NCH-1:0] exp;
    rst = 1'b1; count = 8'd0; lim0 = 8'd3; lim1 = 8'd5; en = 2'b11; mode = 2'b11;
    step();
    rst = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      count = 8'(c);
      step();
      exp = {(c % 5 == 0), (c % 3 == 0)};
      checks++;
      if (tick !== exp) begin
        errors++; $display("FAIL pulse tick c=%0d got=%b exp=%b", c, tick, exp);
      end
      checks++;
      if (clk_out !== exp) begin
        errors++; $display("FAIL pulse clk_out c=%0d got=%b exp=%b", c, clk_out, exp);
      end
      if (c == 15) begin
        checks++;
        if (tick !== 2'b11) begin errors++; $display("FAIL pulse coincident got=%b exp=11", tick); end
      end
    end
  endtask

  task automatic test_overrun();
    logic exp_tick;
    rst = 1'b1; count = 8'd6; lim0 = 8'd4; lim1 = 8'd0; en = 2'b01; mode = 2'b00;
    step();
    rst = 1'b0;
    count = 8'd9;
    step();
    checks++;
    if (tick !== 2'b00) begin errors++; $display("FAIL overrun early tick got=%b exp=00", tick); end
    count = 8'd20; ovr_clr = 2'b01;
    step();
    checks++;
    if (tick !== 2'b01) begin errors++; $display("FAIL overrun jump tick got=%b exp=01", tick); end
    checks++;
    if (overrun !== 2'b01) begin errors++; $display("FAIL overrun set_wins got=%b exp=01", overrun); end
    checks++;
    if (clk_out !== 2'b01) begin errors++; $display("FAIL overrun clk_out got=%b exp=01", clk_out); end
    ovr_clr = 2'b00;
    for (int c = 21; c <= 24; c++) begin
      count = 8'(c);
      step();
      exp_tick = (c == 24);
      checks++;
      if (tick !== {1'b0, exp_tick}) begin
        errors++; $display("FAIL overrun resched tick c=%0d got=%b exp=%b", c, tick, {1'b0, exp_tick});
      end
    end
    checks++;
    if (overrun !== 2'b01) begin errors++; $display("FAIL overrun sticky got=%b exp=01", overrun); end
    checks++;
    if (clk_out !== 2'b00) begin errors++; $display("FAIL overrun clk_out2 got=%b exp=00", clk_out); end
    count = 8'd25; ovr_clr = 2'b01;
    step();
    checks++;
    if (overrun !== 2'b00) begin errors++; $display("FAIL overrun clear got=%b exp=00", overrun); end
    ovr_clr = 2'b00;
  endtask

  task automatic test_enable_limit_reset();
    logic exp_tick;
    logic exp_clk;
    rst = 1'b1; count = 8'd40; lim0 = 8'd6; lim1 = 8'd0; en = 2'b01; mode = 2'b00;
    step();
    rst = 1'b0;
    exp_clk = 1'b0;
    for (int c = 41; c <= 46; c++) begin
      count = 8'(c);
      step();
      exp_tick = (c == 46);
      if (exp_tick) exp_clk = ~exp_clk;
      checks++;
      if (tick !== {1'b0, exp_tick} || clk_out !== {1'b0, exp_clk}) begin
        errors++; $display("FAIL enable first c=%0d tick=%b clk_out=%b exp_tick=%b exp_clk=%b",
                           c, tick, clk_out, exp_tick, exp_clk);
      end
    end
    en = 2'b00;
    for (int c = 47; c <= 60; c++) begin
      count = 8'(c);
      step();
      checks++;
      if (tick !== 2'b00 || clk_out !== 2'b00) begin
        errors++; $display("FAIL disabled c=%0d tick=%b clk_out=%b exp=00/00", c, tick, clk_out);
      end
    end
    en = 2'b01;
    exp_clk = 1'b0;
    for (int c = 61; c <= 66; c++) begin
      count = 8'(c);
      step();
      exp_tick = (c == 66);
      if (exp_tick) exp_clk = ~exp_clk;
      checks++;
      if (tick !== {1'b0, exp_tick} || clk_out !== {1'b0, exp_clk}) begin
        errors++; $display("FAIL reenable c=%0d tick=%b clk_out=%b exp_tick=%b exp_clk=%b",
                           c, tick, clk_out, exp_tick, exp_clk);
      end
    end
    lim0 = 8'd0;
    for (int c = 67; c <= 75; c++) begin
      count = 8'(c);
      step();
      checks++;
      if (tick !== 2'b00 || clk_out !== 2'b00) begin
        errors++; $display("FAIL limit0 c=%0d tick=%b clk_out=%b exp=00/00", c, tick, clk_out);
      end
    end
    lim0 = 8'd6; rst = 1'b1; count = 8'd100;
    step();
    checks++;
    if (tick !== 2'b00 || clk_out !== 2'b00) begin
      errors++; $display("FAIL midreset tick=%b clk_out=%b exp=00/00", tick, clk_out);
    end
    rst = 1'b0;
    for (int c = 101; c <= 106; c++) begin
      count = 8'(c);
      step();
      exp_tick = (c == 106);
      checks++;
      if (tick !== {1'b0, exp_tick}) begin
        errors++; $display("FAIL postreset tick c=%0d got=%b exp=%b", c, tick, {1'b0, exp_tick});
      end
    end
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_wrap();
    test_pulse();
    test_overrun();
    test_enable_limit_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_clk_generator.md
# multi_clk_generator

Parametrised, multi-channel successor to the single-channel event clock generator used by the position subsystem. Each of `NCH` channels watches a shared free-running timestamp `count` and fires an event every `limit[i]` timestamp units. On each event it either toggles a divided clock or emits a one-cycle pulse. Unlike the single-channel block, comparison is wrap-safe, scheduling is drift-free, late events are detected and flagged, and state is reset synchronously.

## Interface
Parameters:
- `NCH`, 4: number of independent channels (1..16).
- `W`, 32: width of `count`, per-channel `limit` and internal due registers.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `count`  in  W: shared free-running timestamp; increments by arbitrary non-negative steps and wraps modulo 2^W.
- `en`  in  NCH: per-channel enable.
- `mode`  in  NCH: per-channel output mode. 0 = toggle (square wave), 1 = pulse.
- `limit`  in  NCH*W: per-channel interval. Channel i uses bits [i*W +: W]. Legal range is 1..2^(W-1)-1.
- `ovr_clr`  in  NCH: per-channel clear for the sticky overrun flag.
- `clk_out`  out  NCH: per-channel generated clock or pulse.
- `tick`  out  NCH: one-cycle strobe on every event, in both modes.
- `overrun`  out  NCH: sticky late-event flag.

## Operation
- Each channel holds a W-bit `due[i]` register. A channel is "reached" when bit W-1 of (count - due[i]) mod 2^W is 0, i.e. a wrap-safe count >= due.
- Reset (`rst`=1): for every i, clk_out=0, tick=0, overrun=0, due[i] <= count + limit[i]. Reset overrides all other inputs.
- Disabled or idle channel (en[i]=0, or limit[i]=0):
  - due[i] <= count + limit[i]
  - clk_out[i]=0, tick[i]=0
  - overrun[i] unchanged, but still cleared by ovr_clr[i]
- Enabled channel, not reached: all state held. In pulse mode, clk_out[i]=0.
- Enabled channel, reached (event):
  - tick[i]=1 for exactly one cycle.
  - clk_out[i] toggles in mode 0; in mode 1 it is 1 for this cycle only.
  - Drift-free reschedule: nd = due[i] + limit[i].
  - If nd is itself already reached by the current count (the channel fell behind by at least one interval), then due[i] <= count + limit[i] and overrun[i] <= 1. Missed events are dropped, never burst.
  - Otherwise due[i] <= nd.
- overrun[i]: set as above, cleared by ovr_clr[i]. Set wins over a clear in the same cycle.
- Mode change while enabled takes effect at the next edge. Switching into pulse mode drops clk_out[i] to 0 unless that cycle is an event.
- All arithmetic is mod 2^W. Behaviour is undefined for limit >= 2^(W-1).
- Channels are fully independent; no shared state except `count`.

## Timing
- Inputs are sampled at rising edge k. The event decision and all outputs are registered and visible after edge k: one-cycle latency from count crossing due to tick/clk_out.
- Minimum event spacing is 1 cycle (limit=1, count +1 per cycle gives a tick every cycle). Mode-0 period is 2*limit timestamp units.
- Enable rising at edge k: the first event is at count >= (count sampled at edge k-1) + limit.
- Enable falling: clk_out and tick are 0 after the same edge.
- A `limit` change takes effect at the next reschedule. An already-scheduled due is not altered.
- Reset mid-operation: outputs are 0 after the reset edge. The first post-reset event is at count >= count_at_reset + limit.

## Test plan
- W=8, NCH=1, mode 0, limit=4, count +1/cycle from 0:
  - tick every 4 cycles (first at count=4)
  - clk_out period of 8 cycles, 50% duty
- Wrap: W=8, due=0xFE, limit=4, count +1/cycle:
  - events at count 0xFE and 0x02
  - no spurious event at 0x00
  - overrun stays 0
- Pulse mode, two channels: limit 3 and 5, count +1/cycle:
  - clk_out equals tick on both channels, high exactly 1 cycle per event
  - coincident event at count 15 fires both channels
- Overrun: limit=4, due=10, count jumps 9→20:
  - one tick
  - due=24
  - overrun=1
  - ovr_clr held in the same cycle as a new overrun leaves overrun=1
- Enable/limit=0/reset: en deasserted mid-period, limit set to 0, and rst asserted while count=100 with limit=6:
  - clk_out=0 and no ticks while en is low or limit=0
  - after reset, first tick at count=106
